tboom_rename_map: RTL and testbench

TBOOM_RENAME_MAP -- requirements
Module: tboom_rename_map

---
 rtl/tboom_rename_map.sv | 163 ++++++++++++++++
 tb/tb_tboom_rename_map.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tboom_rename_map.sv
// Two-lane register rename map table with a single checkpoint snapshot.
// Sources and the old destination mapping are looked up from the current
// map (with i0->i1 intra-bundle bypass) and presented one cycle later.
// x0 is hardwired: it always reads tag 0 and is never remapped.
module tboom_rename_map #(
    parameter int REG_PHYS_ADDR_WIDTH = 6,
    parameter int NUM_ARCH_REGISTERS  = 32,
    parameter int REG_ARCH_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           checkpoint,
    input  logic                           flush,

    input  logic                           i0_rename_valid,
    input  logic [REG_ARCH_ADDR_WIDTH-1:0] i0_rs1,
    input  logic [REG_ARCH_ADDR_WIDTH-1:0] i0_rs2,
    input  logic [REG_ARCH_ADDR_WIDTH-1:0] i0_rd,
    input  logic                           i0_rd_valid,
    input  logic [REG_PHYS_ADDR_WIDTH-1:0] i0_pdst,
    output logic                           i0_out_valid,
    output logic [REG_PHYS_ADDR_WIDTH-1:0] i0_prs1,
    output logic [REG_PHYS_ADDR_WIDTH-1:0] i0_prs2,
    output logic [REG_PHYS_ADDR_WIDTH-1:0] i0_out_pdst,
    output logic [REG_PHYS_ADDR_WIDTH-1:0] i0_pdst_old,

    input  logic                           i1_rename_valid,
    input  logic [REG_ARCH_ADDR_WIDTH-1:0] i1_rs1,
    input  logic [REG_ARCH_ADDR_WIDTH-1:0] i1_rs2,
    input  logic [REG_ARCH_ADDR_WIDTH-1:0] i1_rd,
    input  logic                           i1_rd_valid,
    input  logic [REG_PHYS_ADDR_WIDTH-1:0] i1_pdst,
    output logic                           i1_out_valid,
    output logic [REG_PHYS_ADDR_WIDTH-1:0] i1_prs1,
    output logic [REG_PHYS_ADDR_WIDTH-1:0] i1_prs2,
    output logic [REG_PHYS_ADDR_WIDTH-1:0] i1_out_pdst,
    output logic [REG_PHYS_ADDR_WIDTH-1:0] i1_pdst_old
);

    localparam int PW = REG_PHYS_ADDR_WIDTH;
    localparam int AW = REG_ARCH_ADDR_WIDTH;

    typedef logic [PW-1:0] tag_t;

    // Architectural register 0 always reads as physical tag 0.
    function automatic tag_t arch_read(input logic [AW-1:0] addr, input tag_t entry);
        return (addr == '0) ? '0 : entry;
    endfunction

    tag_t map_q  [NUM_ARCH_REGISTERS];
    tag_t snap_q [NUM_ARCH_REGISTERS];
    tag_t map_nxt[NUM_ARCH_REGISTERS];

    logic i0_wr_p0;
    logic i1_wr_p0;
    logic i1_rs1_byp_p0;
    logic i1_rs2_byp_p0;
    logic i1_rd_byp_p0;

    tag_t i0_prs1_p0, i0_prs2_p0, i0_pdst_old_p0;
    tag_t i1_prs1_p0, i1_prs2_p0, i1_pdst_old_p0;

    logic i0_vld_p1, i1_vld_p1;
    tag_t i0_prs1_p1, i0_prs2_p1, i0_pdst_p1, i0_pdst_old_p1;
    tag_t i1_prs1_p1, i1_prs2_p1, i1_pdst_p1, i1_pdst_old_p1;

    // ---- stage p0: lookup against current map, with i0->i1 bypass ----

    // A lane remaps its destination only when valid, writing, and rd is not x0.
    always_comb begin
        i0_wr_p0 = i0_rename_valid && i0_rd_valid && (i0_rd != '0);
        i1_wr_p0 = i1_rename_valid && i1_rd_valid && (i1_rd != '0);
        // i0_wr_p0 already excludes x0, so a zero source can never bypass.
        i1_rs1_byp_p0 = i0_wr_p0 && (i0_rd == i1_rs1);
        i1_rs2_byp_p0 = i0_wr_p0 && (i0_rd == i1_rs2);
        i1_rd_byp_p0  = i0_wr_p0 && i1_rd_valid && (i0_rd == i1_rd);
    end

    // Source and previous-destination lookups for both lanes.
    always_comb begin
        i0_prs1_p0     = arch_read(i0_rs1, map_q[i0_rs1]);
        i0_prs2_p0     = arch_read(i0_rs2, map_q[i0_rs2]);
        i0_pdst_old_p0 = arch_read(i0_rd,  map_q[i0_rd]);
        i1_prs1_p0     = i1_rs1_byp_p0 ? i0_pdst : arch_read(i1_rs1, map_q[i1_rs1]);
        i1_prs2_p0     = i1_rs2_byp_p0 ? i0_pdst : arch_read(i1_rs2, map_q[i1_rs2]);
        i1_pdst_old_p0 = i1_rd_byp_p0  ? i0_pdst : arch_read(i1_rd,  map_q[i1_rd]);
    end

    // Next map: flush restores the snapshot, otherwise apply i0 then i1 so i1 wins.
    always_comb begin
        for (int i = 0; i < NUM_ARCH_REGISTERS; i++) begin
            map_nxt[i] = map_q[i];
        end
        if (flush) begin
            for (int i = 0; i < NUM_ARCH_REGISTERS; i++) begin
                map_nxt[i] = snap_q[i];
            end
        end else begin
            if (i0_wr_p0) map_nxt[i0_rd] = i0_pdst;
            if (i1_wr_p0) map_nxt[i1_rd] = i1_pdst;
        end
    end

    // Map and snapshot state; a checkpoint during a flush leaves the snapshot as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH_REGISTERS; i++) begin
                map_q[i]  <= tag_t'(i);
                snap_q[i] <= tag_t'(i);
            end
        end else begin
            for (int i = 0; i < NUM_ARCH_REGISTERS; i++) begin
                map_q[i] <= map_nxt[i];
                if (checkpoint && !flush) snap_q[i] <= map_nxt[i];
            end
        end
    end

    // ---- stage p1: registered rename results ----

    // Output register; a flush kills both lanes, tags hold while a lane is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i0_vld_p1      <= 1'b0;
            i1_vld_p1      <= 1'b0;
            i0_prs1_p1     <= '0;
            i0_prs2_p1     <= '0;
            i0_pdst_p1     <= '0;
            i0_pdst_old_p1 <= '0;
            i1_prs1_p1     <= '0;
            i1_prs2_p1     <= '0;
            i1_pdst_p1     <= '0;
            i1_pdst_old_p1 <= '0;
        end else begin
            i0_vld_p1 <= i0_rename_valid && !flush;
            i1_vld_p1 <= i1_rename_valid && !flush;
            if (i0_rename_valid && !flush) begin
                i0_prs1_p1     <= i0_prs1_p0;
                i0_prs2_p1     <= i0_prs2_p0;
                i0_pdst_p1     <= i0_pdst;
                i0_pdst_old_p1 <= i0_pdst_old_p0;
            end
            if (i1_rename_valid && !flush) begin
                i1_prs1_p1     <= i1_prs1_p0;
                i1_prs2_p1     <= i1_prs2_p0;
                i1_pdst_p1     <= i1_pdst;
                i1_pdst_old_p1 <= i1_pdst_old_p0;
            end
        end
    end

    assign i0_out_valid = i0_vld_p1;
    assign i0_prs1      = i0_prs1_p1;
    assign i0_prs2      = i0_prs2_p1;
    assign i0_out_pdst  = i0_pdst_p1;
    assign i0_pdst_old  = i0_pdst_old_p1;
    assign i1_out_valid = i1_vld_p1;
    assign i1_prs1      = i1_prs1_p1;
    assign i1_prs2      = i1_prs2_p1;
    assign i1_out_pdst  = i1_pdst_p1;
    assign i1_pdst_old  = i1_pdst_old_p1;

endmodule

// File: tb/tb_tboom_rename_map.sv
// Bench for tboom_rename_map: directed scenarios followed by random bundles,
// checked against a sequential-rename reference model.
module tb_tboom_rename_map;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       checkpoint = 1'b0, flush = 1'b0;
    logic       i0_rename_valid = 1'b0, i0_rd_valid = 1'b0;
    logic [4:0] i0_rs1 = '0, i0_rs2 = '0, i0_rd = '0;
    logic [5:0] i0_pdst = '0;
    logic       i1_rename_valid = 1'b0, i1_rd_valid = 1'b0;
    logic [4:0] i1_rs1 = '0, i1_rs2 = '0, i1_rd = '0;
    logic [5:0] i1_pdst = '0;
    logic       i0_out_valid, i1_out_valid;
    logic [5:0] i0_prs1, i0_prs2, i0_out_pdst, i0_pdst_old;
    logic [5:0] i1_prs1, i1_prs2, i1_out_pdst, i1_pdst_old;

    int n_assert = 0;
    int n_fail   = 0;
    int mmap[32];
    int msnap[32];

    always #5 clk = ~clk;

    tboom_rename_map #(
        .REG_PHYS_ADDR_WIDTH(6), .NUM_ARCH_REGISTERS(32), .REG_ARCH_ADDR_WIDTH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .checkpoint(checkpoint), .flush(flush),
        .i0_rename_valid(i0_rename_valid), .i0_rs1(i0_rs1), .i0_rs2(i0_rs2),
        .i0_rd(i0_rd), .i0_rd_valid(i0_rd_valid), .i0_pdst(i0_pdst),
        .i0_out_valid(i0_out_valid), .i0_prs1(i0_prs1), .i0_prs2(i0_prs2),
        .i0_out_pdst(i0_out_pdst), .i0_pdst_old(i0_pdst_old),
        .i1_rename_valid(i1_rename_valid), .i1_rs1(i1_rs1), .i1_rs2(i1_rs2),
        .i1_rd(i1_rd), .i1_rd_valid(i1_rd_valid), .i1_pdst(i1_pdst),
        .i1_out_valid(i1_out_valid), .i1_prs1(i1_prs1), .i1_prs2(i1_prs2),
        .i1_out_pdst(i1_out_pdst), .i1_pdst_old(i1_pdst_old)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_assert++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mmap[i]  = i;
            msnap[i] = i;
        end
    endtask

    // Architectural read: x0 is always tag 0.
    function automatic int rd_map(input int m[32], input int a);
        return (a == 0) ? 0 : m[a];
    endfunction

    // One bundle: drive, clock, check next-cycle outputs, advance the model.
    // The model renames i0 fully before i1, so i1 naturally sees i0's write.
    task automatic step(input string nm,
                        input bit v0, input int a1, input int a2, input int ad, input bit w0, input int p0,
                        input bit v1, input int b1, input int b2, input int bd, input bit w1, input int p1,
                        input bit ck, input bit fl);
        int e0s1, e0s2, e0old, e1s1, e1s2, e1old;
        int after0[32];
        int nxt[32];
        i0_rename_valid = v0; i0_rs1 = 5'(a1); i0_rs2 = 5'(a2); i0_rd = 5'(ad);
        i0_rd_valid = w0; i0_pdst = 6'(p0);
        i1_rename_valid = v1; i1_rs1 = 5'(b1); i1_rs2 = 5'(b2); i1_rd = 5'(bd);
        i1_rd_valid = w1; i1_pdst = 6'(p1);
        checkpoint = ck; flush = fl;

        e0s1  = rd_map(mmap, a1);
        e0s2  = rd_map(mmap, a2);
        e0old = rd_map(mmap, ad);
        after0 = mmap;
        if (v0 && w0 && ad != 0) after0[ad] = p0;
        e1s1  = rd_map(after0, b1);
        e1s2  = rd_map(after0, b2);
        e1old = rd_map(after0, bd);

        @(posedge clk);
        #1;
        chk({nm, ".i0_out_valid"}, 32'(i0_out_valid), int'(v0 && !fl));
        chk({nm, ".i1_out_valid"}, 32'(i1_out_valid), int'(v1 && !fl));
        if (v0 && !fl) begin
            chk({nm, ".i0_prs1"}, 32'(i0_prs1), e0s1);
            chk({nm, ".i0_prs2"}, 32'(i0_prs2), e0s2);
            chk({nm, ".i0_out_pdst"}, 32'(i0_out_pdst), p0);
            if (w0 || ad == 0) chk({nm, ".i0_pdst_old"}, 32'(i0_pdst_old), e0old);
        end
        if (v1 && !fl) begin
            chk({nm, ".i1_prs1"}, 32'(i1_prs1), e1s1);
            chk({nm, ".i1_prs2"}, 32'(i1_prs2), e1s2);
            chk({nm, ".i1_out_pdst"}, 32'(i1_out_pdst), p1);
            if (w1 || bd == 0) chk({nm, ".i1_pdst_old"}, 32'(i1_pdst_old), e1old);
        end

        if (fl) begin
            nxt = msnap;
        end else begin
            nxt = after0;
            if (v1 && w1 && bd != 0) nxt[bd] = p1;
        end
        if (ck && !fl) msnap = nxt;
        mmap = nxt;
    endtask

    // Read-only probe of two architectural registers on i0.
    task automatic probe(input string nm, input int r1, input int r2);
        step(nm, 1, r1, r2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".i0_out_valid"}, 32'(i0_out_valid), 0);
        chk({nm, ".i1_out_valid"}, 32'(i1_out_valid), 0);
        chk({nm, ".i0_tags"}, 32'({i0_prs1, i0_prs2, i0_out_pdst, i0_pdst_old}), 0);
        chk({nm, ".i1_tags"}, 32'({i1_prs1, i1_prs2, i1_out_pdst, i1_pdst_old}), 0);
    endtask

    initial begin
        model_reset();
        #2;
        chk_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic rename after reset, then confirm map[5]=32.
        step("basic", 1, 3, 4, 5, 1, 32, 0, 0, 0, 0, 0, 0, 0, 0);
        probe("basic_rd", 5, 3);

        // Same-bundle RAW and WAW on x7; i1 wins the map entry.
        step("bypass", 1, 1, 2, 7, 1, 33, 1, 7, 7, 7, 1, 34, 0, 0);
        probe("bypass_rd", 7, 0);

        // Checkpoint, speculative rename of x5, flush restores 32.
        step("ckpt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("spec", 1, 5, 6, 5, 1, 40, 0, 0, 0, 0, 0, 0, 0, 0);
        step("flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        probe("flush_rd", 5, 7);

        // x0 destination leaves the map alone; x0 source reads 0.
        step("x0", 1, 0, 5, 0, 1, 35, 1, 0, 0, 0, 1, 37, 0, 0);
        probe("x0_rd", 0, 0);

        // Flush with a same-cycle rename: lane is killed, x9 keeps snapshot value.
        step("flush_rn", 1, 9, 9, 9, 1, 36, 1, 9, 9, 9, 1, 38, 0, 1);
        probe("flush_rn_rd", 9, 5);

        // i1 alone, and flush+checkpoint together.
        step("i1only", 0, 0, 0, 0, 0, 0, 1, 5, 7, 12, 1, 41, 0, 0);
        step("fl_ck", 1, 1, 2, 12, 1, 42, 0, 0, 0, 0, 0, 0, 1, 1);
        probe("fl_ck_rd", 12, 7);

        // Random bundles with occasional checkpoints and flushes.
        for (int n = 0; n < 400; n++) begin
            step("rand",
                 1'($urandom_range(0, 3) != 0), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 63),
                 1'($urandom_range(0, 3) != 0), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 63),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 11) == 0));
        end

        // Mid-stream reset: in-flight results vanish at once.
        step("pre_rst0", 1, 1, 2, 5, 1, 50, 1, 3, 4, 6, 1, 51, 0, 0);
        i0_rename_valid = 1'b1; i0_rd = 5'd8; i0_rd_valid = 1'b1; i0_pdst = 6'd52;
        i1_rename_valid = 1'b1; checkpoint = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        i0_rename_valid = 1'b0; i1_rename_valid = 1'b0; checkpoint = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("rst_idle");
        probe("rst_rd", 5, 6);

        // Flush with no checkpoint since reset restores the identity map.
        step("id_ren", 1, 0, 0, 5, 1, 53, 0, 0, 0, 0, 0, 0, 0, 0);
        step("id_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        probe("id_rd", 5, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
